fwft_fifo_gen: RTL and testbench

- Parametrised synchronous FIFO; successor to the fixed-size FWFT block-RAM FIFO wrappers.
- Adds selectable FWFT/standard read mode, runtime programmable thresholds, synchronous flush, and sticky overflow/underflow flags.
- Sits between stream producers/consumers (bus bridges, serial links) on a single clock domain.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_sdp_ram.sv | 26 ++
 rtl/fwft_fifo_gen.sv | 126 ++++++++++++
 tb/tb_fwft_fifo_gen.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared read-mode constants, count-width helper
// and reset/flush flag defaults for the FIFO family.
package fifo_pkg;

  localparam int FWFT_MODE = 1;
  localparam int STD_MODE  = 0;

  typedef struct packed {
    logic pfull;
    logic pempty;
    logic ovf;
    logic udf;
  } flags_t;

  localparam flags_t FLAGS_RST = '{
    pfull:  1'b0,
    pempty: 1'b1,
    ovf:    1'b0,
    udf:    1'b0
  };

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// fifo_sdp_ram: Width x Depth simple dual-port RAM,
// registered read, block-RAM inferable.
module fifo_sdp_ram #(
  parameter int Width = 9,
  parameter int Depth = 16
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(Depth)-1:0] i_waddr,
  input  logic [Width-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(Depth)-1:0] i_raddr,
  output logic [Width-1:0]         o_rdata
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fwft_fifo_gen.sv
// fwft_fifo_gen: synchronous FIFO with FWFT/standard read,
// programmable thresholds, flush and sticky error flags.
module fwft_fifo_gen
  import fifo_pkg::*;
#(
  parameter int Width         = 9,
  parameter int Depth         = 16,
  parameter int FirstWordFall = 1,
  parameter int CountWidth    = cnt_width(Depth)
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Flush,
  input  logic                  Write,
  input  logic [Width-1:0]      Din,
  input  logic                  Read,
  output logic [Width-1:0]      Dout,
  output logic                  Valid,
  output logic                  Full,
  output logic                  Empty,
  input  logic [CountWidth-1:0] ProgFullThresh,
  input  logic [CountWidth-1:0] ProgEmptyThresh,
  output logic                  ProgFull,
  output logic                  ProgEmpty,
  output logic [CountWidth-1:0] DataCount,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int AW = $clog2(Depth);
  localparam bit FWFT = (FirstWordFall == FWFT_MODE);
  localparam bit STD = (FirstWordFall == STD_MODE);
  localparam logic [CountWidth-1:0] FULL_CNT =
    CountWidth'(Depth);

  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CountWidth-1:0] r_cnt;
  logic                  r_valid;
  logic                  r_dz;
  flags_t                r_flg;

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_load;
  logic                  w_valid_nxt;
  logic [CountWidth-1:0] w_cnt_nxt;
  logic [CountWidth-1:0] w_mem_cnt;
  logic [Width-1:0]      w_rdata;
  flags_t                w_flg_nxt;

  assign Full  = (r_cnt == FULL_CNT);
  assign Empty = STD ? (r_cnt == '0) : !r_valid;
  assign w_wr  = Write && !Full;
  assign w_rd  = Read && !Empty;

  // words in RAM not yet moved into the output register
  assign w_mem_cnt = r_cnt - CountWidth'(r_valid);

  assign w_load = FWFT
    ? ((!r_valid || w_rd) && (w_mem_cnt != '0))
    : w_rd;

  assign w_valid_nxt = FWFT
    ? (w_load || (r_valid && !w_rd))
    : w_rd;

  assign w_cnt_nxt = r_cnt + CountWidth'(w_wr)
                   - CountWidth'(w_rd);

  always_comb begin
    w_flg_nxt        = r_flg;
    w_flg_nxt.pfull  = (w_cnt_nxt >= ProgFullThresh);
    w_flg_nxt.pempty = (w_cnt_nxt <= ProgEmptyThresh);
    w_flg_nxt.ovf    = r_flg.ovf | (Write & Full);
    w_flg_nxt.udf    = r_flg.udf | (Read & Empty);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_dz    <= 1'b1;
      r_flg   <= FLAGS_RST;
    end else if (Flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_dz    <= 1'b1;
      r_flg   <= FLAGS_RST;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_load) r_rptr <= r_rptr + AW'(1);
      if (w_load) r_dz <= 1'b0;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_flg   <= w_flg_nxt;
    end
  end

  fifo_sdp_ram #(
    .Width (Width),
    .Depth (Depth)
  ) u_ram (
    .i_clk   (Clk),
    .i_we    (w_wr && !Flush),
    .i_waddr (r_wptr),
    .i_wdata (Din),
    .i_re    (w_load && !Flush),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // RAM output has no reset; mask it until the first load
  assign Dout      = r_dz ? '0 : w_rdata;
  assign Valid     = r_valid;
  assign DataCount = r_cnt;
  assign ProgFull  = r_flg.pfull;
  assign ProgEmpty = r_flg.pempty;
  assign Overflow  = r_flg.ovf;
  assign Underflow = r_flg.udf;

endmodule

// File: tb/tb_fwft_fifo_gen.sv
// tb_fwft_fifo_gen: queue-model scoreboard for FWFT and
// standard FIFOs, plus a directed run on a 32x1024 FIFO.
module tb_fwft_fifo_gen;

  typedef struct {
    int         cnt;
    bit         vld;
    bit         full;
    bit         empty;
    bit         pf;
    bit         pe;
    bit         ovf;
    bit         udf;
    bit         chk;
    logic [8:0] dout;
  } exp_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset_n;
  logic       Flush, Write, Read;
  logic [8:0] Din;
  logic [4:0] pft, pet;
  int         want_pft, want_pet;

  logic [8:0] f_dout, s_dout;
  logic [4:0] f_cnt, s_cnt;
  logic f_vld, f_full, f_empty, f_pf, f_pe, f_ovf, f_udf;
  logic s_vld, s_full, s_empty, s_pf, s_pe, s_ovf, s_udf;

  logic        b_rst_n, b_f, b_w, b_r;
  logic [31:0] b_din, b_dout;
  logic [10:0] b_pft, b_pet, b_cnt;
  logic b_vld, b_full, b_empty, b_pf, b_pe, b_ovf, b_udf;

  int total = 0;
  int bad   = 0;

  fwft_fifo_gen #(
    .Width(9), .Depth(16), .FirstWordFall(1)
  ) u_f (
    .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush),
    .Write(Write), .Din(Din), .Read(Read),
    .Dout(f_dout), .Valid(f_vld), .Full(f_full),
    .Empty(f_empty), .ProgFullThresh(pft),
    .ProgEmptyThresh(pet), .ProgFull(f_pf),
    .ProgEmpty(f_pe), .DataCount(f_cnt),
    .Overflow(f_ovf), .Underflow(f_udf)
  );

  fwft_fifo_gen #(
    .Width(9), .Depth(16), .FirstWordFall(0)
  ) u_s (
    .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush),
    .Write(Write), .Din(Din), .Read(Read),
    .Dout(s_dout), .Valid(s_vld), .Full(s_full),
    .Empty(s_empty), .ProgFullThresh(pft),
    .ProgEmptyThresh(pet), .ProgFull(s_pf),
    .ProgEmpty(s_pe), .DataCount(s_cnt),
    .Overflow(s_ovf), .Underflow(s_udf)
  );

  fwft_fifo_gen #(
    .Width(32), .Depth(1024), .FirstWordFall(1)
  ) u_b (
    .Clk(Clk), .Reset_n(b_rst_n), .Flush(b_f),
    .Write(b_w), .Din(b_din), .Read(b_r),
    .Dout(b_dout), .Valid(b_vld), .Full(b_full),
    .Empty(b_empty), .ProgFullThresh(b_pft),
    .ProgEmptyThresh(b_pet), .ProgFull(b_pf),
    .ProgEmpty(b_pe), .DataCount(b_cnt),
    .Overflow(b_ovf), .Underflow(b_udf)
  );

  // reference model: index 0 = FWFT, 1 = standard
  logic [8:0] mq0[$];
  logic [8:0] mq1[$];
  exp_t       eq0[$];
  exp_t       eq1[$];
  bit         vld_m[2], ovf_m[2], udf_m[2];
  bit         pf_m[2], pe_m[2];
  logic [8:0] last_m[2];

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  function automatic int qsz(input int m);
    return (m == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [8:0] qpop(input int m);
    if (m == 0) return mq0.pop_front();
    return mq1.pop_front();
  endfunction

  function automatic logic [8:0] qfront(input int m);
    if (m == 0) return mq0[0];
    return mq1[0];
  endfunction

  task automatic qpush(input int m, input logic [8:0] d);
    if (m == 0) mq0.push_back(d);
    else mq1.push_back(d);
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    for (int m = 0; m < 2; m++) begin
      vld_m[m] = 0; ovf_m[m] = 0; udf_m[m] = 0;
      pf_m[m] = 0; pe_m[m] = 1; last_m[m] = '0;
    end
  endtask

  task automatic model_step(input int m);
    int n;
    bit fw, aw, ar;
    logic [8:0] pop;
    exp_t e;
    fw = (m == 0);
    n = qsz(m);
    if (Flush) begin
      if (m == 0) mq0.delete();
      else mq1.delete();
      vld_m[m] = 0; ovf_m[m] = 0; udf_m[m] = 0;
      pf_m[m] = 0; pe_m[m] = 1; last_m[m] = '0;
    end else begin
      aw = Write && (n < 16);
      ar = Read && (fw ? vld_m[m] : (n > 0));
      if (Write && !aw) ovf_m[m] = 1;
      if (Read && !ar) udf_m[m] = 1;
      if (ar) begin
        pop = qpop(m);
        if (!fw) last_m[m] = pop;
      end
      // FWFT: a word shows if it was held before this edge
      vld_m[m] = fw ? ((n - int'(ar)) > 0) : ar;
      if (aw) qpush(m, Din);
      pf_m[m] = (qsz(m) >= int'(pft));
      pe_m[m] = (qsz(m) <= int'(pet));
    end
    e.cnt   = qsz(m);
    e.vld   = vld_m[m];
    e.full  = (qsz(m) == 16);
    e.empty = fw ? !vld_m[m] : (qsz(m) == 0);
    e.pf    = pf_m[m];
    e.pe    = pe_m[m];
    e.ovf   = ovf_m[m];
    e.udf   = udf_m[m];
    e.chk   = fw ? (vld_m[m] || Flush) : 1'b1;
    if (fw) e.dout = vld_m[m] ? qfront(m) : '0;
    else e.dout = last_m[m];
    if (m == 0) eq0.push_back(e);
    else eq1.push_back(e);
  endtask

  task automatic cyc(input logic w, input logic [8:0] d,
                     input logic r, input logic f);
    @(posedge Clk);
    #3;
    Write = w; Din = d; Read = r; Flush = f;
    pft = 5'(want_pft);
    pet = 5'(want_pet);
    model_step(0);
    model_step(1);
  endtask

  task automatic mon_chk(input int m, input exp_t e);
    string p;
    p = (m == 0) ? "fwft" : "std";
    cmp({p, ".count"},
        32'(m == 0 ? f_cnt : s_cnt), 32'(e.cnt));
    cmp({p, ".valid"},
        32'(m == 0 ? f_vld : s_vld), 32'(e.vld));
    cmp({p, ".full"},
        32'(m == 0 ? f_full : s_full), 32'(e.full));
    cmp({p, ".empty"},
        32'(m == 0 ? f_empty : s_empty), 32'(e.empty));
    cmp({p, ".progfull"},
        32'(m == 0 ? f_pf : s_pf), 32'(e.pf));
    cmp({p, ".progempty"},
        32'(m == 0 ? f_pe : s_pe), 32'(e.pe));
    cmp({p, ".overflow"},
        32'(m == 0 ? f_ovf : s_ovf), 32'(e.ovf));
    cmp({p, ".underflow"},
        32'(m == 0 ? f_udf : s_udf), 32'(e.udf));
    if (e.chk)
      cmp({p, ".dout"},
          32'(m == 0 ? f_dout : s_dout), 32'(e.dout));
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (eq0.size() > 0) mon_chk(0, eq0.pop_front());
      if (eq1.size() > 0) mon_chk(1, eq1.pop_front());
    end
  end

  task automatic bcyc(input logic w, input logic [31:0] d,
                      input logic r, input logic f);
    @(posedge Clk);
    #3;
    b_w = w; b_din = d; b_r = r; b_f = f;
  endtask

  initial begin
    Reset_n = 0; b_rst_n = 0;
    Flush = 0; Write = 0; Read = 0; Din = '0;
    want_pft = 14; want_pet = 5;
    pft = 5'd14; pet = 5'd5;
    b_f = 0; b_w = 0; b_r = 0; b_din = '0;
    b_pft = 11'd1000; b_pet = 11'd10;
    model_reset();
    repeat (2) @(posedge Clk);
    #3;
    cmp("rst.fwft.count", 32'(f_cnt), 32'd0);
    cmp("rst.fwft.empty", 32'(f_empty), 32'd1);
    cmp("rst.fwft.valid", 32'(f_vld), 32'd0);
    cmp("rst.fwft.dout", 32'(f_dout), 32'd0);
    cmp("rst.fwft.progempty", 32'(f_pe), 32'd1);
    cmp("rst.std.empty", 32'(s_empty), 32'd1);
    cmp("rst.std.full", 32'(s_full), 32'd0);
    Reset_n = 1;
    b_rst_n = 1;

    // first word latency
    cyc(1, 9'h1A5, 0, 0);
    cyc(0, 0, 0, 0);
    cmp("t1.valid_after_N", 32'(f_vld), 32'd0);
    cmp("t1.count_after_N", 32'(f_cnt), 32'd1);
    cyc(0, 0, 0, 0);
    cmp("t1.valid_after_N1", 32'(f_vld), 32'd1);
    cmp("t1.empty_after_N1", 32'(f_empty), 32'd0);
    cmp("t1.dout_after_N1", 32'(f_dout), 32'h1A5);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cmp("t1.empty_after_read", 32'(f_empty), 32'd1);
    cmp("t1.count_after_read", 32'(f_cnt), 32'd0);

    // fill, overflow, drain
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 9'(i), 0, 0);
    cyc(1, 9'h1FF, 0, 0);
    cyc(0, 0, 0, 0);
    cmp("t2.full", 32'(f_full), 32'd1);
    cmp("t2.count", 32'(f_cnt), 32'd16);
    cmp("t2.progfull", 32'(f_pf), 32'd1);
    cmp("t2.overflow", 32'(f_ovf), 32'd1);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cmp("t2.drained", 32'(f_cnt), 32'd0);
    cmp("t2.no_bubble", 32'(f_udf), 32'd0);

    // steady state with pointer wrap
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 9'(50 + i), 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 40; i++) cyc(1, 9'(100 + i), 1, 0);
    cyc(0, 0, 0, 0);
    cmp("t3.count", 32'(f_cnt), 32'd8);
    cmp("t3.std_count", 32'(s_cnt), 32'd8);

    // standard read mode
    cyc(0, 0, 0, 1);
    cyc(1, 9'h055, 0, 0);
    cyc(1, 9'h0AA, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cmp("t4.valid_pulse", 32'(s_vld), 32'd1);
    cmp("t4.dout", 32'(s_dout), 32'h055);
    cyc(0, 0, 0, 0);
    cmp("t4.valid_drop", 32'(s_vld), 32'd0);
    cmp("t4.dout_hold", 32'(s_dout), 32'h055);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cmp("t4.underflow", 32'(s_udf), 32'd1);
    cmp("t4.dout_unchanged", 32'(s_dout), 32'h0AA);

    // ProgEmpty threshold
    cyc(0, 0, 0, 1);
    want_pet = 5;
    for (int i = 0; i < 5; i++) cyc(1, 9'(i), 0, 0);
    cyc(0, 0, 0, 0);
    cmp("t5.pe_at5", 32'(f_pe), 32'd1);
    cyc(1, 9'd5, 0, 0);
    cyc(0, 0, 0, 0);
    cmp("t5.count6", 32'(f_cnt), 32'd6);
    cmp("t5.pe_at6", 32'(f_pe), 32'd0);
    want_pet = 7;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cmp("t5.pe_thresh7", 32'(f_pe), 32'd1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      int wp;
      wp = ((i / 100) % 2 == 1) ? 30 : 75;
      if ($urandom_range(0, 39) == 0)
        want_pft = int'($urandom_range(0, 16));
      if ($urandom_range(0, 39) == 0)
        want_pet = int'($urandom_range(0, 16));
      cyc(int'($urandom_range(0, 99)) < wp,
          9'($urandom),
          int'($urandom_range(0, 99)) < (100 - wp),
          $urandom_range(0, 79) == 0);
    end
    cyc(0, 0, 0, 0);

    // deep FIFO: flush priority and async reset
    bcyc(0, 0, 1, 0);
    for (int i = 0; i < 300; i++) bcyc(1, 32'(100 + i), 0, 0);
    bcyc(0, 0, 0, 0);
    cmp("t6.count300", 32'(b_cnt), 32'd300);
    cmp("t6.underflow", 32'(b_udf), 32'd1);
    cmp("t6.dout_head", b_dout, 32'd100);
    cmp("t6.pe_low", 32'(b_pe), 32'd0);
    bcyc(1, 32'h7, 1, 1);
    bcyc(0, 0, 0, 0);
    cmp("t6.flush_count", 32'(b_cnt), 32'd0);
    cmp("t6.flush_empty", 32'(b_empty), 32'd1);
    cmp("t6.flush_ovf", 32'(b_ovf), 32'd0);
    cmp("t6.flush_udf", 32'(b_udf), 32'd0);
    cmp("t6.flush_dout", b_dout, 32'd0);
    cmp("t6.flush_pe", 32'(b_pe), 32'd1);
    for (int i = 0; i < 5; i++) bcyc(1, 32'(500 + i), 0, 0);
    bcyc(0, 0, 0, 0);
    bcyc(0, 0, 0, 0);
    cmp("t6.count5", 32'(b_cnt), 32'd5);
    cmp("t6.dout500", b_dout, 32'd500);
    b_rst_n = 0;
    #1;
    cmp("t6.rst_count", 32'(b_cnt), 32'd0);
    cmp("t6.rst_valid", 32'(b_vld), 32'd0);
    cmp("t6.rst_empty", 32'(b_empty), 32'd1);
    cmp("t6.rst_dout", b_dout, 32'd0);
    cmp("t6.rst_full", 32'(b_full), 32'd0);
    cmp("t6.rst_pf", 32'(b_pf), 32'd0);
    cmp("t6.rst_pe", 32'(b_pe), 32'd1);
    bcyc(0, 0, 0, 0);
    b_rst_n = 1;

    repeat (2) @(posedge Clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
